// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver. Deserializes 11-bit frames,
//            checks framing and queues good scan codes in a small FIFO
//            that the keyboard controller drains via ready/nextdata_n.
// Options  : PS2_PARITY_CHECK_EN - when defined, frames with bad odd
//            parity are rejected; otherwise the parity bit is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam logic [12:0]           c_timeout = 13'(TIMEOUT);
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_cnt_one = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    // Synchronizers (reset to the idle-high bus level)
    logic [2:0]  ps2_clk_sync_q,  ps2_clk_sync_d;
    logic [2:0]  ps2_data_sync_q, ps2_data_sync_d;

    // Frame receiver
    state_t      state_q,     state_d;
    logic [3:0]  bitcnt_q,    bitcnt_d;
    logic [9:0]  rxbuf_q,     rxbuf_d;
    logic [12:0] idle_cnt_q,  idle_cnt_d;
    logic        frame_err_q, frame_err_d;

    // FIFO
    logic [7:0]            mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] w_ptr_q,    w_ptr_d;
    logic [DEPTH_LOG2-1:0] r_ptr_q,    r_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,    count_d;
    logic                  overflow_q, overflow_d;

    // Combinational helpers
    logic       w_fall;
    logic       w_data_bit;
    logic       w_parity_ok;
    logic       w_frame_ok;
    logic       w_push;
    logic [7:0] w_push_byte;
    logic       w_full;
    logic       w_pop;
    logic       w_push_ok;

    // Edge detect on the two oldest clock sync stages; data taken from the
    // oldest data stage, which is stable around a PS/2 falling edge.
    assign w_fall      = ps2_clk_sync_q[2] & ~ps2_clk_sync_q[1];
    assign w_data_bit  = ps2_data_sync_q[2];
    assign w_push_byte = rxbuf_q[8:1];

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity over data + parity bit: an odd number of ones is good.
    assign w_parity_ok = ^rxbuf_q[9:1];
`else
    assign w_parity_ok = 1'b1;
`endif

    // Before the stop-bit shift: rxbuf[0]=start, [8:1]=data, [9]=parity.
    assign w_frame_ok = ~rxbuf_q[0] & w_data_bit & w_parity_ok;

    // Receiver next-state: shift bits in, check the frame on bit 10, timeout
    always_comb begin
        ps2_clk_sync_d  = {ps2_clk_sync_q[1:0], ps2_clk};
        ps2_data_sync_d = {ps2_data_sync_q[1:0], ps2_data};
        bitcnt_d        = bitcnt_q;
        rxbuf_d         = rxbuf_q;
        idle_cnt_d      = idle_cnt_q;
        frame_err_d     = 1'b0;
        w_push          = 1'b0;

        if (w_fall) begin
            rxbuf_d    = {w_data_bit, rxbuf_q[9:1]};
            idle_cnt_d = 13'd0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d = 4'd0;
                if (w_frame_ok) begin
                    w_push = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (state_q == S_RECV) begin
            if (idle_cnt_q == c_timeout) begin
                // Stalled sender: drop the partial frame
                bitcnt_d    = 4'd0;
                idle_cnt_d  = 13'd0;
                frame_err_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 13'd1;
            end
        end else begin
            idle_cnt_d = 13'd0;
        end

        state_d = (bitcnt_d == 4'd0) ? S_IDLE : S_RECV;
    end

    // FIFO next-state: a pop frees a slot before a same-cycle push is judged
    always_comb begin
        w_full     = count_q[DEPTH_LOG2];
        w_pop      = ~nextdata_n & (count_q != '0);
        w_push_ok  = w_push & (~w_full | w_pop);
        w_ptr_d    = w_push_ok ? (w_ptr_q + c_ptr_one) : w_ptr_q;
        r_ptr_d    = w_pop     ? (r_ptr_q + c_ptr_one) : r_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (w_push_ok && !w_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (!w_push_ok && w_pop) begin
            count_d = count_q - c_cnt_one;
        end

        if (w_push && !w_push_ok) begin
            overflow_d = 1'b1;
        end else if (w_pop) begin
            overflow_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ps2_clk_sync_q  <= 3'b111;
            ps2_data_sync_q <= 3'b111;
            state_q         <= S_IDLE;
            bitcnt_q        <= 4'd0;
            rxbuf_q         <= 10'd0;
            idle_cnt_q      <= 13'd0;
            frame_err_q     <= 1'b0;
            w_ptr_q         <= '0;
            r_ptr_q         <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
        end else begin
            ps2_clk_sync_q  <= ps2_clk_sync_d;
            ps2_data_sync_q <= ps2_data_sync_d;
            state_q         <= state_d;
            bitcnt_q        <= bitcnt_d;
            rxbuf_q         <= rxbuf_d;
            idle_cnt_q      <= idle_cnt_d;
            frame_err_q     <= frame_err_d;
            w_ptr_q         <= w_ptr_d;
            r_ptr_q         <= r_ptr_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since data is masked when empty
    always_ff @(posedge clk) begin
        if (clrn && w_push_ok) begin
            mem_q[w_ptr_q] <= w_push_byte;
        end
    end

    assign ready     = (count_q != '0);
    assign data      = ready ? mem_q[r_ptr_q] : 8'h00;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Scoreboard bench for ps2_rx_fifo. Stimulus pushes expected bytes
//            and expected frame_err events; a monitor checks every pop and
//            every frame_err pulse against them. Honors PS2_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_rx_fifo;

    localparam int DEPTH_LOG2 = 3;
    localparam int TIMEOUT    = 200;

    logic       clk        = 1'b0;
    logic       clrn       = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int n_checks   = 0;
    int n_errors   = 0;
    int fe_pending = 0;
    logic [7:0] exp_q[$];

    ps2_rx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every pop against the scoreboard, account for frame_err
    logic prev_fe = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (clrn && !nextdata_n && ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got %0h expected no byte", data);
            end else begin
                chk("pop_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (frame_err) begin
            n_checks++;
            if (prev_fe) begin
                n_errors++;
                $display("FAIL frame_err_width: got pulse longer than 1 cycle expected 1 cycle");
            end else if (fe_pending == 0) begin
                n_errors++;
                $display("FAIL frame_err_unexpected: got 1 expected 0");
            end else begin
                fe_pending--;
            end
        end
        prev_fe = frame_err;
    end

    // Frame image, bit 0 first: start, data LSB first, odd parity, stop
    function automatic logic [10:0] mk(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    // Drive nbits of a frame; PS/2 clock half-period is 20 system clocks
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(mk(b, 1'b0), 11);
    endtask

    task automatic pop1();
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},     {31'h0, ready},     32'h0);
        chk({tag, "_overflow"},  {31'h0, overflow},  32'h0);
        chk({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
        chk({tag, "_data"},      {24'h0, data},      32'h0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [10:0] fb;

        // Reset values
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame 0x1C with latency measurement on the stop-bit edge
        exp_q.push_back(8'h1C);
        fb = mk(8'h1C, 1'b0);
        send_bits(fb, 10);
        @(negedge clk) ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 12);
        chk("ready_latency_3_to_4", {31'h0, (lat >= 3 && lat <= 4)}, 32'h1);
        chk("first_data", {24'h0, data}, 32'h1C);
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        pop1();
        chk("empty_after_pop", {31'h0, ready}, 32'h0);

        // Break sequence F0 1C without popping
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        send_frame(8'hF0);
        send_frame(8'h1C);
        chk("break_ready", {31'h0, ready}, 32'h1);
        chk("break_head", {24'h0, data}, 32'hF0);
        pop1();
        pop1();
        chk("break_drained", {31'h0, ready}, 32'h0);

        // Nine frames into an 8-deep FIFO
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back(8'(8'h11 + k));
            send_frame(8'(8'h11 + k));
        end
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        chk("ovf_ready", {31'h0, ready}, 32'h1);
        pop1();
        chk("ovf_cleared_by_pop", {31'h0, overflow}, 32'h0);
        chk("ovf_second_byte", {24'h0, data}, 32'h12);
        @(negedge clk) nextdata_n = 1'b0;
        repeat (10) @(negedge clk);
        nextdata_n = 1'b1;
        chk("ovf_drained", {31'h0, ready}, 32'h0);

        // Flipped parity bit
`ifdef PS2_PARITY_CHECK_EN
        fe_pending++;
`else
        exp_q.push_back(8'h1C);
`endif
        send_bits(mk(8'h1C, 1'b1), 11);
        repeat (5) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        chk("parity_rejected_ready", {31'h0, ready}, 32'h0);
`else
        chk("parity_ignored_ready", {31'h0, ready}, 32'h1);
        pop1();
`endif
        chk("parity_fe_accounted", fe_pending, 32'h0);

        // Timeout after 5 bits, then a clean frame 0x32
        fe_pending++;
        send_bits(mk(8'h32, 1'b0), 5);
        repeat (TIMEOUT + 30) @(negedge clk);
        chk("timeout_fe_seen", fe_pending, 32'h0);
        chk("timeout_no_push", {31'h0, ready}, 32'h0);
        exp_q.push_back(8'h32);
        send_frame(8'h32);
        chk("after_timeout_ready", {31'h0, ready}, 32'h1);
        pop1();
        chk("after_timeout_empty", {31'h0, ready}, 32'h0);

        // Reset mid-frame with three bytes queued
        send_frame(8'hA1);
        send_frame(8'hA2);
        send_frame(8'hA3);
        chk("pre_reset_ready", {31'h0, ready}, 32'h1);
        send_bits(mk(8'h44, 1'b0), 4);
        @(negedge clk) clrn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A);
        chk("post_reset_ready", {31'h0, ready}, 32'h1);
        chk("post_reset_data", {24'h0, data}, 32'h5A);
        pop1();
        chk("post_reset_alone", {31'h0, ready}, 32'h0);

        // Scoreboard must be fully consumed
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        chk("frame_err_all_seen", fe_pending, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
